// File: rtl/binary_search_ctrl.sv
// Control FSM for the binary-search datapath (32x8 sync RAM plus In/L/M/H).
// It sequences load, RAM-latency wait, compare and narrowing commands, and
// ends with a Done/Miss result held until Start is dropped.
// Optional feature macro: BSEARCH_TIMEOUT_EN ends the search with a miss
// after MAX_ITER probes. Without it, only a match or window collapse ends it.
module binary_search_ctrl #(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned MAX_ITER    = 6
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic       Start,
    input  logic       Mem_Eq_In,
    input  logic       H_Eq_L,
    input  logic       In_Gt_Mem,
    output logic       Load_Regs,
    output logic       Set_Found,
    output logic       Set_High,
    output logic       Set_Low,
    output logic       Set_Middle,
    output logic       Busy,
    output logic       Done,
    output logic       Miss,
    output logic [2:0] Iter
);

    localparam int unsigned CNT_W  = 3;
    localparam int unsigned ITER_W = 3;
    localparam logic [ITER_W-1:0] ITER_SAT = 3'd7;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_CMP  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    // Elaboration-time parameter range checks
    if (WAIT_CYCLES < 1 || WAIT_CYCLES > 7) begin : g_bad_wait
        $error("binary_search_ctrl: WAIT_CYCLES must be 1..7");
    end
    if (MAX_ITER < 1 || MAX_ITER > 7) begin : g_bad_iter
        $error("binary_search_ctrl: MAX_ITER must be 1..7");
    end

    logic [2:0]        state;
    logic [2:0]        state_next;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_next;
    logic [ITER_W-1:0] iter_next;
    logic [ITER_W-1:0] iter_inc;
    logic              miss_next;

    // Reserved datapath command, never used by this controller
    assign Set_Middle = 1'b0;

    // Next-state, counters and the CMP-cycle command pulses
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        iter_next  = Iter;
        miss_next  = Miss;
        Set_Found  = 1'b0;
        Set_High   = 1'b0;
        Set_Low    = 1'b0;
        iter_inc   = (Iter == ITER_SAT) ? Iter : Iter + ITER_W'(1);

        case (state)
            S_IDLE: begin
                if (Start) begin
                    state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                iter_next  = '0;
                miss_next  = 1'b0;
                // LOAD itself covers one cycle of the RAM latency
                cnt_next   = CNT_W'(WAIT_CYCLES - 1);
                state_next = S_WAIT;
            end
            S_WAIT: begin
                cnt_next = cnt - CNT_W'(1);
                if (cnt <= CNT_W'(1)) begin
                    state_next = S_CMP;
                end
            end
            S_CMP: begin
                iter_next = iter_inc;
                if (Mem_Eq_In) begin
                    Set_Found  = 1'b1;
                    miss_next  = 1'b0;
                    state_next = S_DONE;
                end else if (H_Eq_L) begin
                    miss_next  = 1'b1;
                    state_next = S_DONE;
`ifdef BSEARCH_TIMEOUT_EN
                end else if (iter_inc == ITER_W'(MAX_ITER)) begin
                    miss_next  = 1'b1;
                    state_next = S_DONE;
`endif
                end else if (In_Gt_Mem) begin
                    Set_Low    = 1'b1;
                    cnt_next   = CNT_W'(WAIT_CYCLES);
                    state_next = S_WAIT;
                end else begin
                    Set_High   = 1'b1;
                    cnt_next   = CNT_W'(WAIT_CYCLES);
                    state_next = S_WAIT;
                end
            end
            S_DONE: begin
                if (!Start) begin
                    miss_next  = 1'b0;
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        // No datapath command may escape while reset is applied
        if (Reset) begin
            Set_Found = 1'b0;
            Set_High  = 1'b0;
            Set_Low   = 1'b0;
        end
    end

    // State, counters and registered status outputs
    always_ff @(posedge clk) begin
        if (Reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            Iter      <= '0;
            Miss      <= 1'b0;
            Load_Regs <= 1'b0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            Iter      <= iter_next;
            Miss      <= miss_next;
            Load_Regs <= (state_next == S_LOAD);
            Busy      <= (state_next != S_IDLE) && (state_next != S_DONE);
            Done      <= (state_next == S_DONE);
        end
    end

endmodule
